// File: rtl/ram_arbiter_rr.sv
// Round-robin arbiter that shares one RAM port among NCORES requesters.
// Each grant is followed by at least one idle cycle. Aborts on RAM error or timeout.
module ram_arbiter_rr #(
  parameter int unsigned NCORES  = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NCORES-1:0]          creq_ren,
  input  logic [NCORES-1:0]          creq_wen,
  input  logic [NCORES*ADDR_W-1:0]   caddr,
  input  logic [NCORES*DATA_W-1:0]   cstore,
  output logic [NCORES-1:0]          cwait,
  output logic [NCORES*DATA_W-1:0]   cload,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic [ADDR_W-1:0]          ramaddr,
  output logic [DATA_W-1:0]          ramstore,
  input  logic [DATA_W-1:0]          ramload,
  input  logic [1:0]                 ramstate,
  output logic [$clog2(NCORES)-1:0]  grant_id,
  output logic                       err_pulse
);

  localparam int unsigned IdW  = $clog2(NCORES);
  localparam int unsigned TmoW = $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT - 1);
  localparam logic [IdW-1:0]  LastId = IdW'(NCORES - 1);
  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;

  logic [NCORES-1:0] req;
  logic [ADDR_W-1:0] addr_a  [NCORES];
  logic [DATA_W-1:0] store_a [NCORES];
  logic [DATA_W-1:0] load_a  [NCORES];
  logic              found;
  logic [IdW-1:0]    winner;
  logic [IdW:0]      scan;
  logic [IdW-1:0]    next_ptr;

  always_comb begin
    for (int i = 0; i < int'(NCORES); i++) begin
      addr_a[i]  = caddr[i*ADDR_W +: ADDR_W];
      store_a[i] = cstore[i*DATA_W +: DATA_W];
    end
  end

  assign req      = creq_ren | creq_wen;
  assign next_ptr = (grant_q == LastId) ? '0 : grant_q + IdW'(1);

  // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so non-power-of-2 counts work.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int k = 0; k < int'(NCORES); k++) begin
      scan = {1'b0, rr_ptr_q} + (IdW+1)'(k);
      if (scan >= (IdW+1)'(NCORES)) scan = scan - (IdW+1)'(NCORES);
      if (!found && req[scan[IdW-1:0]]) begin
        found  = 1'b1;
        winner = scan[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    tmo_d    = tmo_q;
    err_d    = 1'b0;
    cwait    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int i = 0; i < int'(NCORES); i++) load_a[i] = '0;

    // Outputs are forced low while reset is asserted, not just after the next edge.
    if (nRST) begin
      unique case (state_q)
        StIdle: begin
          cwait = req;
          if (found) begin
            grant_d = winner;
            tmo_d   = '0;
            state_d = StGrant;
          end
        end
        StGrant: begin
          cwait          = req;
          cwait[grant_q] = 1'b1;
          ramWEN         = creq_wen[grant_q];
          ramREN         = creq_ren[grant_q] & ~creq_wen[grant_q];
          ramaddr        = addr_a[grant_q];
          ramstore       = store_a[grant_q];
          if (tmo_q != TmoMax) tmo_d = tmo_q + TmoW'(1);

          if (!req[grant_q]) begin
            state_d = StIdle;
          end else if (ramstate == RamAccess) begin
            cwait[grant_q]  = 1'b0;
            load_a[grant_q] = ramload;
            rr_ptr_d        = next_ptr;
            state_d         = StIdle;
          end else if (ramstate == RamError || tmo_q == TmoMax) begin
            err_d    = 1'b1;
            rr_ptr_d = next_ptr;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < int'(NCORES); g++) begin : g_cload
    assign cload[g*DATA_W +: DATA_W] = load_a[g];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  assign grant_id  = grant_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Scoreboard bench for ram_arbiter_rr: three cores, short timeout, address-driven RAM model.
module tb_ram_arbiter_rr;
  localparam int unsigned N = 3, AW = 32, DW = 32, TMO = 4;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [N-1:0]    creq_ren, creq_wen;
  logic [N*AW-1:0] caddr;
  logic [N*DW-1:0] cstore;
  logic [N-1:0]    cwait;
  logic [N*DW-1:0] cload;
  logic            ramREN, ramWEN;
  logic [AW-1:0]   ramaddr;
  logic [DW-1:0]   ramstore;
  logic [DW-1:0]   ramload;
  logic [1:0]      ramstate;
  logic [1:0]      grant_id;
  logic            err_pulse;

  ram_arbiter_rr #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .creq_ren(creq_ren), .creq_wen(creq_wen), .caddr(caddr),
    .cstore(cstore), .cwait(cwait), .cload(cload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .grant_id(grant_id), .err_pulse(err_pulse)
  );

  always #5 CLK = ~CLK;

  // RAM model: stuck address stays BUSY, err address errors once, others ACCESS after busy_n.
  logic [AW-1:0] stuck_addr, err_addr;
  int busy_n;
  int busy_cnt  = 0;
  int err_given = 0;
  assign ramstate = !(ramREN | ramWEN)                      ? 2'd0 :
                    (ramaddr == stuck_addr)                 ? 2'd1 :
                    (ramaddr == err_addr && err_given == 0) ? 2'd3 :
                    (busy_cnt < busy_n)                     ? 2'd1 : 2'd2;
  always @(posedge CLK) begin
    busy_cnt <= (ramREN | ramWEN) ? busy_cnt + 1 : 0;
    if (ramstate == 2'd3) err_given <= err_given + 1;
  end

  typedef struct packed {
    logic        kind;   // 0 = completed access, 1 = error pulse
    logic [1:0]  core;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] data;   // cload of the core, or grant length before an abort
    logic [31:0] others; // any non-zero cload outside the served core
  } ev_t;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  run      = 0;
  int  last_run = 0;
  bit  prev_acc = 1'b0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic ev_t acc_ev(input logic [1:0] core, input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] store,
                                 input logic [31:0] data);
    ev_t e;
    e = '{kind: 1'b0, core: core, ren: ren, wen: wen, addr: addr, store: store, data: data,
          others: 32'd0};
    return e;
  endfunction

  function automatic ev_t err_ev(input logic [1:0] core, input int len);
    ev_t e;
    e = '{kind: 1'b1, core: core, ren: 1'b0, wen: 1'b0, addr: 32'd0, store: 32'd0,
          data: 32'(len), others: 32'd0};
    return e;
  endfunction

  task automatic post_event(input ev_t got);
    ev_t exp;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %0h, expected no event", got);
    end else begin
      exp = sb_q.pop_front();
      check("sb_event", 256'(got), 256'(exp));
    end
  endtask

  task automatic mon_step();
    ev_t             got;
    bit              acc_now;
    logic [N*DW-1:0] rest;
    acc_now = 1'b0;
    if (!nRST) begin
      run      = 0;
      prev_acc = 1'b0;
      return;
    end
    if (ramREN | ramWEN) run++;
    else if (run != 0) begin
      last_run = run;
      run      = 0;
    end
    for (int i = 0; i < int'(N); i++) begin
      if ((creq_ren[i] | creq_wen[i]) && !cwait[i]) begin
        rest = cload;
        rest[i*DW +: DW] = '0;
        got = '{kind: 1'b0, core: 2'(i), ren: ramREN, wen: ramWEN, addr: ramaddr,
                store: ramstore, data: cload[i*DW +: DW], others: {31'd0, |rest}};
        post_event(got);
        acc_now = 1'b1;
      end
    end
    if (err_pulse) begin
      got = '{kind: 1'b1, core: grant_id, ren: ramREN, wen: ramWEN, addr: ramaddr,
              store: ramstore, data: 32'(last_run), others: {31'd0, |cload}};
      post_event(got);
    end
    if (acc_now) check("idle_between_grants", 256'(prev_acc), 256'(0));
    prev_acc = acc_now;
  endtask

  // Wait for the scoreboard to empty, then drop all requests just after the next edge.
  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      #1;
      if (sb_q.size() == 0) break;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d events pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
    @(posedge CLK);
    #1;
    creq_ren = '0;
    creq_wen = '0;
  endtask

  function automatic logic [255:0] all_outs();
    return 256'({cwait, cload, ramREN, ramWEN, ramaddr, ramstore, grant_id, err_pulse});
  endfunction

  initial begin
    bit seen;
    nRST       = 1'b0;
    creq_ren   = '0;
    creq_wen   = '0;
    caddr      = '0;
    cstore     = '0;
    ramload    = '0;
    stuck_addr = '1;
    err_addr   = '1;
    busy_n     = 0;

    fork
      forever begin
        @(negedge CLK);
        mon_step();
      end
    join_none

    #12;
    check("reset_outputs", all_outs(), 256'(0));
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Single read, two BUSY cycles before ACCESS.
    caddr[0 +: AW] = 32'h100;
    ramload        = 32'hDEAD_BEEF;
    busy_n         = 2;
    sb_q.push_back(acc_ev(2'd0, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF));
    creq_ren[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (!cwait[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("read0_done", 256'(seen), 256'(1));
    @(negedge CLK);
    check("read0_cwait_one_cycle", 256'({cwait[0], ramREN}), 256'(2'b10));
    @(posedge CLK);
    #1 creq_ren = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("read0_sb_empty", 256'(sb_q.size()), 256'(0));

    // Read and write both set on core1: treated as a write.
    busy_n          = 0;
    ramload         = 32'h0BAD_F00D;
    caddr[AW +: AW] = 32'h140;
    cstore[DW +: DW] = 32'h55;
    sb_q.push_back(acc_ev(2'd1, 1'b0, 1'b1, 32'h140, 32'h55, 32'h0BAD_F00D));
    creq_ren[1] = 1'b1;
    creq_wen[1] = 1'b1;
    drain("rw_both_core1", 20);

    // Reset while core1 is waiting in GRANT.
    stuck_addr      = 32'h180;
    caddr[AW +: AW] = 32'h180;
    creq_ren[1]     = 1'b1;
    repeat (2) @(negedge CLK);
    check("grant1_wait", 256'({cwait[1], ramREN, grant_id}), 256'({1'b1, 1'b1, 2'd1}));
    #2 nRST = 1'b0;
    #1;
    check("reset_mid_grant", all_outs(), 256'(0));
    creq_ren   = '0;
    stuck_addr = '1;
    @(posedge CLK);
    #1 nRST = 1'b1;

    // All cores request continuously, immediate ACCESS: order must start at core0.
    cstore  = '0;
    ramload = 32'hCAFE_0000;
    for (int i = 0; i < int'(N); i++) caddr[i*AW +: AW] = 32'h1000 + 32'(4 * i);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < int'(N); i++)
        sb_q.push_back(acc_ev(2'(i), 1'b1, 1'b0, 32'h1000 + 32'(4 * i), 32'h0, 32'hCAFE_0000));
    creq_ren = '1;
    drain("rr_order", 60);

    // Core0 address never completes: four GRANT cycles, abort, core1 served next.
    stuck_addr     = 32'h200;
    caddr[0 +: AW] = 32'h200;
    caddr[AW +: AW] = 32'h204;
    sb_q.push_back(err_ev(2'd0, 4));
    sb_q.push_back(acc_ev(2'd1, 1'b1, 1'b0, 32'h204, 32'h0, 32'hCAFE_0000));
    creq_ren = 3'b011;
    drain("timeout_abort", 60);

    // RAM ERROR on core0 write: core1 goes next, then core0 is re-granted.
    stuck_addr       = '1;
    err_addr         = 32'h300;
    caddr[0 +: AW]   = 32'h300;
    caddr[AW +: AW]  = 32'h304;
    cstore[0 +: DW]  = 32'hA0A0;
    cstore[DW +: DW] = 32'hB1B1;
    sb_q.push_back(err_ev(2'd0, 1));
    sb_q.push_back(acc_ev(2'd1, 1'b0, 1'b1, 32'h304, 32'hB1B1, 32'hCAFE_0000));
    sb_q.push_back(acc_ev(2'd0, 1'b0, 1'b1, 32'h300, 32'hA0A0, 32'hCAFE_0000));
    creq_wen = 3'b011;
    drain("error_regrant", 60);

    repeat (3) @(posedge CLK);
    #1;
    check("sb_leftover", 256'(sb_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
